// File: rtl/ula_seq.sv
// Sequencer around an external combinational ALU: accumulator load, one-cycle
// execute and a valid/ready result hold stage with a completed-operation counter.
module ula_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_load,
    input  logic [1:0] in_op,
    input  logic [7:0] in_data,
    output logic [7:0] ula_a,
    output logic [7:0] ula_b,
    output logic [1:0] ula_cond,
    input  logic [7:0] ula_out,
    input  logic       ula_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic [7:0] acc,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] b_reg;
    logic [1:0] op_reg;
    logic       accept_cmd;
    logic       accept_res;

    assign accept_cmd = (state == IDLE) && in_valid;
    assign accept_res = (state == HOLD) && res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid && !in_load) next_state = EXEC;
            EXEC:    next_state = HOLD;
            HOLD:    if (accept_res) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    // ALU operands come straight from registers so they only move on write edges
    assign ula_a    = acc;
    assign ula_b    = b_reg;
    assign ula_cond = op_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= 8'h00;
            b_reg     <= 8'h00;
            op_reg    <= 2'b00;
            res_data  <= 8'h00;
            res_carry <= 1'b0;
            res_valid <= 1'b0;
            op_count  <= 8'h00;
        end else begin
            if (accept_cmd) begin
                if (in_load) begin
                    acc <= in_data;
                end else begin
                    b_reg  <= in_data;
                    op_reg <= in_op;
                end
            end
            if (state == EXEC) begin
                res_data  <= ula_out;
                res_carry <= ula_carry;
                res_valid <= 1'b1;
                // add/sub write back; compare-style ops leave the accumulator alone
                if (!op_reg[1]) begin
                    acc <= ula_out;
                end
            end
            if (accept_res) begin
                res_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: table of directed commands, stall/reset
// corner sequences, and 256 random operations against an arithmetic model.
module tb_ula_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_load;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic [7:0] ula_a;
    logic [7:0] ula_b;
    logic [1:0] ula_cond;
    logic [7:0] ula_out;
    logic       ula_carry;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic [7:0] acc;
    logic [7:0] op_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] obs_data;
    logic       obs_carry;
    logic [7:0] obs_acc;

    always #5 clk = ~clk;

    ula_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_load   (in_load),
        .in_op     (in_op),
        .in_data   (in_data),
        .ula_a     (ula_a),
        .ula_b     (ula_b),
        .ula_cond  (ula_cond),
        .ula_out   (ula_out),
        .ula_carry (ula_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .acc       (acc),
        .op_count  (op_count)
    );

    // Reference ALU: add, subtract (carry = borrow), equality flag, any-common-bit flag
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        int ia = a;
        int ib = b;
        int r;
        logic c;
        case (op)
            2'd0: begin r = (ia + ib) % 256; c = (ia + ib) > 255; end
            2'd1: begin r = (ia - ib + 256) % 256; c = ia < ib; end
            2'd2: begin r = (ia == ib) ? 1 : 0; c = 1'b0; end
            default: begin r = ((a & b) != 0) ? 1 : 0; c = 1'b0; end
        endcase
        return {c, 8'(r)};
    endfunction

    always_comb begin
        {ula_carry, ula_out} = alu_ref(ula_a, ula_b, ula_cond);
    end

    typedef struct {
        logic       load;
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one command; for ALU ops, walk it through EXEC/HOLD and accept the result
    task automatic applyStimulus(input logic load, input logic [1:0] op,
                                 input logic [7:0] data, input int ready_delay);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        in_load  = load;
        in_op    = op;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        if (!load) begin
            checkOutput("exec_res_valid_low", 16'(res_valid), 16'd0);
            checkOutput("exec_in_ready_low", 16'(in_ready), 16'd0);
            checkOutput("ula_b_operand", 16'(ula_b), 16'(data));
            checkOutput("ula_cond_operand", 16'(ula_cond), 16'(op));
            tick();
            checkOutput("latency_res_valid", 16'(res_valid), 16'd1);
            obs_data  = res_data;
            obs_carry = res_carry;
            obs_acc   = acc;
            checkOutput("ula_a_is_acc", 16'(ula_a), 16'(acc));
            for (int i = 0; i < ready_delay; i++) begin
                tick();
                checkOutput("hold_res_data_stable", 16'(res_data), 16'(obs_data));
                checkOutput("hold_res_valid", 16'(res_valid), 16'd1);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            checkOutput("res_valid_cleared", 16'(res_valid), 16'd0);
        end else begin
            obs_acc = acc;
        end
    endtask

    initial begin
        logic [7:0] model_acc;
        logic [7:0] model_count;
        logic [8:0] r;

        vecs[0] = '{1'b1, 2'd0, 8'h06, 8'h00, 1'b0, 8'h06};
        vecs[1] = '{1'b0, 2'd0, 8'h60, 8'h66, 1'b0, 8'h66};
        vecs[2] = '{1'b1, 2'd0, 8'hF0, 8'h00, 1'b0, 8'hF0};
        vecs[3] = '{1'b0, 2'd0, 8'h20, 8'h10, 1'b1, 8'h10};
        vecs[4] = '{1'b1, 2'd0, 8'h66, 8'h00, 1'b0, 8'h66};
        vecs[5] = '{1'b0, 2'd2, 8'h66, 8'h01, 1'b0, 8'h66};
        vecs[6] = '{1'b0, 2'd1, 8'h10, 8'h56, 1'b0, 8'h56};
        vecs[7] = '{1'b0, 2'd1, 8'h60, 8'hF6, 1'b1, 8'hF6};
        vecs[8] = '{1'b0, 2'd3, 8'h0F, 8'h01, 1'b0, 8'hF6};
        vecs[9] = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b0, 8'hF6};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_load   = 1'b0;
        in_op     = 2'd0;
        in_data   = 8'h00;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_acc", 16'(acc), 16'h00);
        checkOutput("reset_res_valid", 16'(res_valid), 16'd0);
        checkOutput("reset_op_count", 16'(op_count), 16'd0);
        checkOutput("reset_in_ready", 16'(in_ready), 16'd1);

        model_count = 8'd0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].load, vecs[i].op, vecs[i].data, i % 3);
            if (!vecs[i].load) begin
                model_count++;
                checkOutput("vec_res_data", 16'(obs_data), 16'(vecs[i].exp_data));
                checkOutput("vec_res_carry", 16'(obs_carry), 16'(vecs[i].exp_carry));
                checkOutput("vec_op_count", 16'(op_count), 16'(model_count));
            end
            checkOutput("vec_acc", 16'(obs_acc), 16'(vecs[i].exp_acc));
        end

        // Stall in HOLD while a load command is offered; nothing may be accepted
        in_valid = 1'b1; in_load = 1'b0; in_op = 2'd0; in_data = 8'h08;
        tick();
        in_load = 1'b1; in_data = 8'hAA;
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_res_valid", 16'(res_valid), 16'd1);
            checkOutput("stall_res_data", 16'(res_data), 16'hFE);
            checkOutput("stall_acc", 16'(acc), 16'hFE);
            checkOutput("stall_in_ready", 16'(in_ready), 16'd0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        res_ready = 1'b0;
        model_count++;
        checkOutput("stall_accept_clear", 16'(res_valid), 16'd0);
        checkOutput("stall_accept_count", 16'(op_count), 16'(model_count));
        tick();
        checkOutput("stall_load_ignored", 16'(acc), 16'hFE);

        // Reset while holding a result abandons it
        in_valid = 1'b1; in_load = 1'b0; in_op = 2'd0; in_data = 8'h01;
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("pre_reset_hold", 16'(res_valid), 16'd1);
        rst       = 1'b1;
        res_ready = 1'b1;
        tick();
        rst       = 1'b0;
        res_ready = 1'b0;
        checkOutput("hold_reset_res_valid", 16'(res_valid), 16'd0);
        checkOutput("hold_reset_acc", 16'(acc), 16'h00);
        checkOutput("hold_reset_op_count", 16'(op_count), 16'h00);
        checkOutput("hold_reset_in_ready", 16'(in_ready), 16'd1);

        model_acc   = 8'h00;
        model_count = 8'h00;
        for (int i = 0; i < 256; i++) begin
            logic [1:0] op;
            logic [7:0] d;
            if ($urandom_range(0, 3) == 0) begin
                d = 8'($urandom_range(0, 255));
                applyStimulus(1'b1, 2'd0, d, 0);
                model_acc = d;
                checkOutput("rand_load_acc", 16'(obs_acc), 16'(model_acc));
            end
            op = 2'($urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            r  = alu_ref(model_acc, d, op);
            applyStimulus(1'b0, op, d, $urandom_range(0, 3));
            if (op < 2) model_acc = r[7:0];
            model_count = model_count + 8'd1;
            checkOutput("rand_res_data", 16'(obs_data), 16'(r[7:0]));
            checkOutput("rand_res_carry", 16'(obs_carry), 16'(r[8]));
            checkOutput("rand_acc", 16'(obs_acc), 16'(model_acc));
            checkOutput("rand_op_count", 16'(op_count), 16'(model_count));
        end
        checkOutput("wrap_op_count_256", 16'(op_count), 16'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
